// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial CLA add/subtract sequencer.
package cla_pkg;

    // Width of one slice pushed through the shared adder per cycle.
    localparam int NIBBLE_W = 4;

    // Operation select encoding on op_sub.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Sequencer states; 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_state_e;

endpackage

// File: rtl/cla_adder4bits.sv
// 4-bit carry-lookahead adder: all carries are derived in parallel from
// generate/propagate terms rather than rippled bit to bit.
module cla_adder4bits (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms and flattened lookahead carry equations.
    always_comb begin
        g    = A & B;
        p    = A ^ B;
        c[0] = Cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        Sum  = p ^ c[3:0];
        Cout = c[4];
    end

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Nibble-serial add/subtract sequencer. One 4-bit CLA is reused for every
// slice of a WIDTH-bit operation, LSB nibble first, with the carry held in a
// register between slices.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are 1. The producer holds its payload stable while valid=1 and
// ready=0; ready never depends on anything the transfer itself changes.
// Input side: in_valid/in_ready carry {op_sub, a, b, cin}. Output side:
// out_valid/out_ready carry {sum, cout, ovf}, which hold while stalled.
module cla_serial_add_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = $clog2(NIB) + 1;

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("cla_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    cla_state_e state;
    cla_state_e state_nxt;

    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic                carry_reg;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    sum_reg;
    logic                cout_reg;
    logic                ovf_reg;

    logic [NIBBLE_W-1:0] a_sl;
    logic [NIBBLE_W-1:0] b_sl;
    logic [NIBBLE_W-1:0] cla_sum;
    logic                cla_cout;
    logic                accept;
    logic                last_slice;

    // Ready and transfer qualifiers; ready is forced low while in reset.
    always_comb begin
        in_ready   = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
        accept     = in_valid && in_ready;
        last_slice = (cnt == CNT_W'(NIB - 1));
        out_valid  = (state == DONE);
        sum        = sum_reg;
        cout       = cout_reg;
        ovf        = ovf_reg;
    end

    // Slice mux: select the nibble addressed by the slice counter.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NIB; i++) begin
            if (cnt == CNT_W'(i)) begin
                a_sl = a_reg[i*NIBBLE_W +: NIBBLE_W];
                b_sl = b_reg[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    cla_adder4bits u_cla (
        .A    (a_sl),
        .B    (b_sl),
        .Cin  (carry_reg),
        .Sum  (cla_sum),
        .Cout (cla_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE can chain straight into RUN on a new accept.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (last_slice) state_nxt = DONE;
            DONE: begin
                if (out_ready) begin
                    state_nxt = accept ? RUN : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then one slice per RUN cycle.
    // Subtraction is A + ~B + 1, so the inversion and the +1 are folded in
    // at capture time and RUN never needs to know the operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= (op_sub == OP_SUB) ? ~b : b;
            carry_reg <= (op_sub == OP_SUB) ? 1'b1 : cin;
            cnt       <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NIB; i++) begin
                if (cnt == CNT_W'(i)) begin
                    sum_reg[i*NIBBLE_W +: NIBBLE_W] <= cla_sum;
                end
            end
            carry_reg <= cla_cout;
            cnt       <= cnt + 1'b1;
            if (last_slice) begin
                cout_reg <= cla_cout;
                ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                         && (cla_sum[NIBBLE_W-1] != a_reg[WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed bench for the nibble-serial CLA sequencer: a WIDTH=16 instance for
// the scenario tests and a WIDTH=4 instance for the exhaustive sweep.
module tb_cla_serial_add_ctrl;

    logic clk;
    logic rst_n;

    // WIDTH=16 instance signals
    logic        iv16, ir16, op16, cin16, ov16, or16, co16, ovf16;
    logic [15:0] a16, b16, s16;

    // WIDTH=4 instance signals
    logic       iv4, ir4, op4, cin4, ov4, or4, co4, ovf4;
    logic [3:0] a4, b4, s4;

    int tests_run;
    int tests_failed;

    cla_serial_add_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .op_sub(op16), .a(a16), .b(b16), .cin(cin16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(ovf16)
    );

    cla_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .op_sub(op4), .a(a4), .b(b4), .cin(cin4),
        .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(ovf4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks (WIDTH=16) ----------------
    // Present one operand set and hold it until accepted (bounded).
    task automatic start16(input logic op, input logic [15:0] a, input logic [15:0] b,
                           input logic c);
        int n;
        n = 0;
        while (!ir16 && n < 20) begin
            tick();
            n++;
        end
        tests_run++;
        if (!ir16) begin
            tests_failed++;
            $display("FAIL start16_ready_timeout: in_ready=%0b required 1", ir16);
        end
        op16 = op; a16 = a; b16 = b; cin16 = c; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
    endtask

    // Count cycles after the accept edge until out_valid (bounded).
    task automatic wait16(output int lat);
        lat = 0;
        while (!ov16 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Accept the pending result for one cycle.
    task automatic consume16;
        or16 = 1'b1;
        tick();
        or16 = 1'b0;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        tests_run++;
        if (ov16 !== 1'b0 || s16 !== 16'h0 || co16 !== 1'b0 || ovf16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: out_valid=%0b sum=%h cout=%0b ovf=%0b required 0/0000/0/0",
                     ov16, s16, co16, ovf16);
        end
        tests_run++;
        if (ir16 !== 1'b0 || ir4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready: in_ready16=%0b in_ready4=%0b required 0", ir16, ir4);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (ir16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_in_ready: in_ready=%0b required 1", ir16);
        end
    endtask

    task automatic run_vec(input string name, input logic op, input logic [15:0] a,
                           input logic [15:0] b, input logic c, input logic [15:0] es,
                           input logic ec, input logic eo);
        int lat;
        start16(op, a, b, c);
        wait16(lat);
        tests_run++;
        if (lat !== 4) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d cycles required 4", name, lat);
        end
        tests_run++;
        if (s16 !== es || co16 !== ec || ovf16 !== eo) begin
            tests_failed++;
            $display("FAIL %s_result: sum=%h cout=%0b ovf=%0b required sum=%h cout=%0b ovf=%0b",
                     name, s16, co16, ovf16, es, ec, eo);
        end
        consume16();
        tests_run++;
        if (ov16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_drop: out_valid=%0b required 0 after out_ready", name, ov16);
        end
    endtask

    task automatic test_add;
        run_vec("add_basic",  1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_vec("add_carry",  1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_vec("add_ovf",    1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_vec("add_cin",    1'b0, 16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0, 1'b0);
    endtask

    task automatic test_sub;
        run_vec("sub_borrow", 1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_vec("sub_ovf",    1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back;
        int lat;
        int bad;
        start16(1'b0, 16'h1111, 16'h2222, 1'b0);
        wait16(lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (ov16 !== 1'b1 || s16 !== 16'h3333 || co16 !== 1'b0 || ovf16 !== 1'b0
                || ir16 !== 1'b0) bad++;
            tick();
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL backpressure_hold: %0d bad cycles, sum=%h out_valid=%0b in_ready=%0b required 3333/1/0",
                     bad, s16, ov16, ir16);
        end
        // Release and present a new op in the same cycle.
        or16 = 1'b1;
        #1;
        tests_run++;
        if (ir16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_in_ready: in_ready=%0b required 1 with out_ready=1", ir16);
        end
        op16 = 1'b0; a16 = 16'h0100; b16 = 16'h0200; cin16 = 1'b0; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        or16 = 1'b0;
        tests_run++;
        if (ov16 !== 1'b0 || ir16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL chain_to_run: out_valid=%0b in_ready=%0b required 0/0", ov16, ir16);
        end
        wait16(lat);
        tests_run++;
        if (lat !== 4 || s16 !== 16'h0300) begin
            tests_failed++;
            $display("FAIL chain_result: latency=%0d sum=%h required 4/0300", lat, s16);
        end
        consume16();
    endtask

    task automatic test_reset_mid_run;
        int lat;
        start16(1'b0, 16'h0FFF, 16'h0001, 1'b0);
        tick();              // first slice done, now in second RUN cycle
        rst_n = 1'b0;
        tick();
        tests_run++;
        if (ov16 !== 1'b0 || s16 !== 16'h0000 || ir16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_run_reset: out_valid=%0b sum=%h in_ready=%0b required 0/0000/0",
                     ov16, s16, ir16);
        end
        rst_n = 1'b1;
        tick();
        tick();
        tests_run++;
        if (ov16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: out_valid=%0b required 0", ov16);
        end
        start16(1'b0, 16'h0001, 16'h0001, 1'b0);
        wait16(lat);
        tests_run++;
        if (lat !== 4 || s16 !== 16'h0002 || co16 !== 1'b0 || ovf16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_op: latency=%0d sum=%h cout=%0b ovf=%0b required 4/0002/0/0",
                     lat, s16, co16, ovf16);
        end
        consume16();
    endtask

    task automatic test_width4_exhaustive;
        int errs;
        int n;
        int stall;
        logic [4:0] exp_full;
        logic       exp_ovf;
        logic [3:0] av;
        logic [3:0] bv;
        errs = 0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    av = ia[3:0];
                    bv = ib[3:0];
                    exp_full = {1'b0, av} + {1'b0, bv} + {4'b0, ic[0]};
                    exp_ovf  = (av[3] == bv[3]) && (exp_full[3] != av[3]);
                    n = 0;
                    while (!ir4 && n < 20) begin tick(); n++; end
                    op4 = 1'b0; a4 = av; b4 = bv; cin4 = ic[0]; iv4 = 1'b1;
                    tick();
                    iv4 = 1'b0;
                    n = 0;
                    while (!ov4 && n < 20) begin tick(); n++; end
                    stall = $urandom_range(0, 3);
                    for (int s = 0; s < stall; s++) tick();
                    tests_run++;
                    if (ov4 !== 1'b1 || {co4, s4} !== exp_full || ovf4 !== exp_ovf) begin
                        tests_failed++;
                        errs++;
                        if (errs <= 8)
                            $display("FAIL w4_add a=%h b=%h cin=%0d: valid=%0b {cout,sum}=%h ovf=%0b required 1/%h/%0b",
                                     av, bv, ic, ov4, {co4, s4}, ovf4, exp_full, exp_ovf);
                    end
                    or4 = 1'b1;
                    tick();
                    or4 = 1'b0;
                end
            end
        end
    endtask

    // main sequence and final report
    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        iv16 = 1'b0; op16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; or16 = 1'b0;
        iv4  = 1'b0; op4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0; or4  = 1'b0;
        #1;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_mid_run();
        test_width4_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
